// File: rtl/vga_sync_gen.sv
// 640x480@60 Hz VGA timing generator: pixel-rate enable, h/v pixel counters and
// registered sync / video_on / frame_start decode aligned with the counters.
module vga_sync_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_p_tick,
    output logic [9:0] o_pixel_x,
    output logic [9:0] o_pixel_y,
    output logic       o_video_on,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_frame_start
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISP);
    localparam logic [9:0] V_VIS    = 10'(V_DISP);
    localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] w_div_next;
    logic             r_p_tick;
    logic [9:0]       r_h_count;
    logic [9:0]       r_v_count;
    logic [9:0]       w_h_next;
    logic [9:0]       w_v_next;
    logic             w_frame_wrap;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_frame_start;

    // Next-state prescaler and counter values; counters move only in a tick clk.
    always_comb begin
        w_div_next   = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
        w_h_next     = r_h_count;
        w_v_next     = r_v_count;
        w_frame_wrap = 1'b0;
        if (r_p_tick) begin
            if (r_h_count == H_LAST) begin
                w_h_next = 10'd0;
                if (r_v_count == V_LAST) begin
                    w_v_next     = 10'd0;
                    w_frame_wrap = 1'b1;
                end else begin
                    w_v_next = r_v_count + 10'd1;
                end
            end else begin
                w_h_next = r_h_count + 10'd1;
            end
        end else begin
            w_h_next = r_h_count;
        end
    end

    // State registers; decodes use next-state counts so they line up with pixel_x/pixel_y.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_cnt     <= '0;
            r_p_tick      <= 1'b0;
            r_h_count     <= 10'd0;
            r_v_count     <= 10'd0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= w_div_next;
            r_p_tick      <= (w_div_next == DIV_LAST);
            r_h_count     <= w_h_next;
            r_v_count     <= w_v_next;
            r_hsync       <= !((w_h_next >= HS_START) && (w_h_next < HS_END));
            r_vsync       <= !((w_v_next >= VS_START) && (w_v_next < VS_END));
            r_video_on    <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
            r_frame_start <= w_frame_wrap;
        end
    end

    assign o_p_tick      = r_p_tick;
    assign o_pixel_x     = r_h_count;
    assign o_pixel_y     = r_v_count;
    assign o_video_on    = r_video_on;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_frame_start = r_frame_start;

endmodule
